// File: rtl/n_term_cfg_pipe_tile.sv
// North-terminal tile: N wire ends loop back to S wire beginnings through local cfg flops.
// Loopback is combinational; frame pass-through has PIPE_STAGES cycles of latency (0..2).
// No backpressure: the frame column never stalls, and every input cycle is forwarded.
//
// Ports:
//   CLK, RST                  rising-edge clock, asynchronous active-high reset
//   N_END / S_BEG             loopback wire ends in / wire beginnings out (LOOP_W bits)
//   FrameData / FrameData_O   configuration row data in / forwarded to the next tile
//   FrameStrobe / FrameStrobe_O frame strobes in / forwarded to the next tile
//   cfg_err                   sticky flag: more than one strobe bit was seen in a cycle
//   frame_wr_cnt              saturating count of accepted local frame writes
module n_term_cfg_pipe_tile #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int LOOP_W          = 52,
  parameter int CFG_FRAMES      = 2,
  parameter int CFG_BASE        = 0,
  parameter int PIPE_STAGES     = 1,
  parameter int CNT_W           = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [LOOP_W-1:0]          N_END,
  output logic [LOOP_W-1:0]          S_BEG,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic                       cfg_err,
  output logic [CNT_W-1:0]           frame_wr_cnt
);

  localparam int CFG_W = CFG_FRAMES * FrameBitsPerRow;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Parameter legality: refuse to elaborate an unusable tile.
  // ---------------------------------------------------------------------------
  if (PIPE_STAGES < 0 || PIPE_STAGES > 2) begin : g_bad_pipe
    $error("n_term_cfg_pipe_tile: PIPE_STAGES must be 0, 1 or 2");
  end
  if (LOOP_W + 1 > CFG_W) begin : g_bad_loop
    $error("n_term_cfg_pipe_tile: LOOP_W+1 exceeds local configuration bits");
  end
  if (CFG_BASE < 0 || CFG_FRAMES < 1 || CFG_BASE + CFG_FRAMES > MaxFramesPerCol) begin : g_bad_range
    $error("n_term_cfg_pipe_tile: local frame range outside the strobe bus");
  end

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  logic [CFG_W-1:0]      cfg_q;
  logic [CFG_FRAMES-1:0] ls;
  logic                  multi_hot;

  assign ls = FrameStrobe[CFG_BASE +: CFG_FRAMES];

  // x & (x-1) clears the lowest set bit; anything left means two or more strobes.
  assign multi_hot = |(FrameStrobe & (FrameStrobe - MaxFramesPerCol'(1)));

  // ---------------------------------------------------------------------------
  // Local configuration, error flag and write counter.
  // A multi-hot strobe word blocks every local write, even to strobed local frames.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cfg_q        <= '0;
      cfg_err      <= 1'b0;
      frame_wr_cnt <= '0;
    end else begin
      if (multi_hot) begin
        cfg_err <= 1'b1;
      end else begin
        for (int f = 0; f < CFG_FRAMES; f++) begin
          if (ls[f]) begin
            cfg_q[f*FrameBitsPerRow +: FrameBitsPerRow] <= FrameData;
          end
        end
        // At most one ls bit can be set here, so one write means one count.
        if (|ls && frame_wr_cnt != CNT_MAX) begin
          frame_wr_cnt <= frame_wr_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Loopback: optional bit reversal, then per-wire enable.
  // ---------------------------------------------------------------------------
  logic [LOOP_W-1:0] n_rev;
  logic [LOOP_W-1:0] src;

  for (genvar i = 0; i < LOOP_W; i++) begin : g_rev
    assign n_rev[i] = N_END[LOOP_W-1-i];
  end

  assign src   = cfg_q[LOOP_W] ? n_rev : N_END;
  assign S_BEG = cfg_q[LOOP_W-1:0] & src;

  // Spare configuration bits above the reverse flag have no function in this tile.
  if (CFG_W > LOOP_W + 1) begin : g_spare
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_q[CFG_W-1:LOOP_W+1];
  end

  // ---------------------------------------------------------------------------
  // Frame pass-through: free-running delay line, independent of write/error logic.
  // ---------------------------------------------------------------------------
  if (PIPE_STAGES == 0) begin : g_pipe0
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;
  end else begin : g_pipe
    logic [FrameBitsPerRow-1:0] data_q [PIPE_STAGES];
    logic [MaxFramesPerCol-1:0] stb_q  [PIPE_STAGES];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        for (int s = 0; s < PIPE_STAGES; s++) begin
          data_q[s] <= '0;
          stb_q[s]  <= '0;
        end
      end else begin
        data_q[0] <= FrameData;
        stb_q[0]  <= FrameStrobe;
        for (int s = 1; s < PIPE_STAGES; s++) begin
          data_q[s] <= data_q[s-1];
          stb_q[s]  <= stb_q[s-1];
        end
      end
    end

    assign FrameData_O   = data_q[PIPE_STAGES-1];
    assign FrameStrobe_O = stb_q[PIPE_STAGES-1];
  end

endmodule

// File: tb/tb_n_term_cfg_pipe_tile.sv
// Bench for n_term_cfg_pipe_tile: three instances (0, 1 and 2 pipe stages; the
// 0-stage one has a 2-bit counter) share one stimulus stream and one model.
// Outputs are sampled on the falling clock edge.
module tb_n_term_cfg_pipe_tile;

  logic        CLK = 1'b0;
  logic        RST;
  logic [51:0] N_END;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;

  logic [51:0] s_beg0, s_beg1, s_beg2;
  logic [31:0] fd_o0, fd_o1, fd_o2;
  logic [19:0] fs_o0, fs_o1, fs_o2;
  logic        err0, err1, err2;
  logic [1:0]  cnt0;
  logic [7:0]  cnt1, cnt2;

  n_term_cfg_pipe_tile #(.PIPE_STAGES(0), .CNT_W(2)) dut0 (
    .CLK(CLK), .RST(RST), .N_END(N_END), .S_BEG(s_beg0),
    .FrameData(FrameData), .FrameData_O(fd_o0),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(fs_o0),
    .cfg_err(err0), .frame_wr_cnt(cnt0));

  n_term_cfg_pipe_tile #(.PIPE_STAGES(1)) dut1 (
    .CLK(CLK), .RST(RST), .N_END(N_END), .S_BEG(s_beg1),
    .FrameData(FrameData), .FrameData_O(fd_o1),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(fs_o1),
    .cfg_err(err1), .frame_wr_cnt(cnt1));

  n_term_cfg_pipe_tile #(.PIPE_STAGES(2)) dut2 (
    .CLK(CLK), .RST(RST), .N_END(N_END), .S_BEG(s_beg2),
    .FrameData(FrameData), .FrameData_O(fd_o2),
    .FrameStrobe(FrameStrobe), .FrameStrobe_O(fs_o2),
    .cfg_err(err2), .frame_wr_cnt(cnt2));

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [63:0] m_cfg;
  logic        m_err;
  int          m_cnt8;
  int          m_cnt2;
  // Scoreboards of {strobe, data} still in flight through the 1- and 2-stage pipes;
  // the front entry is what the DUT output must currently show.
  logic [51:0] q1[$];
  logic [51:0] q2[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [51:0] exp_sbeg(input logic [63:0] c, input logic [51:0] n);
    logic [51:0] r;
    for (int i = 0; i < 52; i++) r[i] = c[i] & (c[52] ? n[51-i] : n[i]);
    return r;
  endfunction

  task automatic reset_model();
    m_cfg = '0; m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    q1.delete(); q1.push_back('0);
    q2.delete(); q2.push_back('0); q2.push_back('0);
  endtask

  task automatic check_outputs();
    logic [51:0] exp_s;
    exp_s = exp_sbeg(m_cfg, N_END);
    chk("s_beg_p0", s_beg0, exp_s);
    chk("s_beg_p1", s_beg1, exp_s);
    chk("s_beg_p2", s_beg2, exp_s);
    chk("err_p0", err0, m_err);
    chk("err_p1", err1, m_err);
    chk("err_p2", err2, m_err);
    chk("cnt_w2", cnt0, m_cnt2[1:0]);
    chk("cnt_p1", cnt1, m_cnt8[7:0]);
    chk("cnt_p2", cnt2, m_cnt8[7:0]);
    chk("pass_data_p0", fd_o0, FrameData);
    chk("pass_stb_p0", fs_o0, FrameStrobe);
    chk("pipe_p1", {fs_o1, fd_o1}, q1[0]);
    chk("pipe_p2", {fs_o2, fd_o2}, q2[0]);
  endtask

  // Drive one input cycle (called away from the rising edge), take the edge,
  // update the model, then check everything on the following falling edge.
  task automatic cycle(input logic [31:0] d, input logic [19:0] s, input logic [51:0] n);
    FrameData = d; FrameStrobe = s; N_END = n;
    q1.push_back({s, d});
    q2.push_back({s, d});
    #1 check_outputs();
    @(posedge CLK);
    if (RST) begin
      void'(q1.pop_back());
      void'(q2.pop_back());
    end else begin
      void'(q1.pop_front());
      void'(q2.pop_front());
      if ($countones(s) > 1) begin
        m_err = 1'b1;
      end else if (s[1:0] != 2'b00) begin
        if (s[0]) m_cfg[31:0] = d;
        else      m_cfg[63:32] = d;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
    @(negedge CLK);
    check_outputs();
  endtask

  localparam logic [51:0] ONES = '1;
  localparam logic [51:0] TOP  = 52'd1 << 51;

  initial begin
    logic [51:0] saved;
    logic [31:0] rd;
    logic [19:0] rs;
    logic [51:0] rn;

    // Reset state
    RST = 1'b1; N_END = ONES; FrameData = '0; FrameStrobe = '0;
    reset_model();
    #2 check_outputs();
    chk("rst_sbeg", s_beg1, 52'h0);
    chk("rst_fs_o", fs_o1, 20'h0);

    // A write strobed while reset is held must be dropped
    cycle(32'hFFFF_FFFF, 20'h1, ONES);
    chk("rst_write_dropped", cnt1, 8'd0);
    chk("rst_write_sbeg", s_beg1, 52'h0);
    RST = 1'b0;

    // Single local write to frame 0
    cycle(32'h0000_000F, 20'h1, ONES);
    chk("wr0_sbeg", s_beg1, 52'hF);
    chk("wr0_cnt", cnt1, 8'd1);
    chk("wr0_fd_o_1edge", fd_o1, 32'h0000_000F);
    cycle(32'h0, 20'h0, ONES);

    // Reverse mode
    cycle(32'h0010_0000, 20'h2, ONES);
    cycle(32'h0000_0001, 20'h1, ONES);
    cycle(32'h0, 20'h0, TOP);
    chk("rev_sbeg", s_beg1, 52'h1);
    cycle(32'h0, 20'h0, 52'h1);
    chk("rev_sbeg_low", s_beg1, 52'h0);

    // Strobe error: two bits set
    cycle(32'h0, 20'h0, TOP);
    saved = s_beg1;
    cycle(32'hFFFF_FFFF, 20'h3, TOP);
    chk("err_sbeg_held", s_beg1, saved);
    chk("err_flag", err1, 1'b1);
    chk("err_cnt_held", cnt1, 8'd3);
    chk("err_fs_o_p1", fs_o1, 20'h3);
    cycle(32'h0, 20'h0, TOP);
    chk("err_fs_o_p2", fs_o2, 20'h3);

    // Valid write after error: accepted, flag stays sticky
    cycle(32'h0000_00FF, 20'h1, ONES);
    chk("err_sticky", err1, 1'b1);
    chk("post_err_cnt", cnt1, 8'd4);
    chk("post_err_sbeg", s_beg1, 52'hFF);

    // Non-local strobe: forwarded only
    saved = s_beg1;
    cycle(32'hFFFF_FFFF, 20'h400, ONES);
    chk("nonlocal_sbeg", s_beg1, saved);
    chk("nonlocal_cnt", cnt1, 8'd4);
    chk("sat_cnt_w2", cnt0, 2'd3);

    // Back-to-back writes to different frames, then a repeat to frame 0
    cycle(32'hA5A5_A5A5, 20'h1, ONES);
    cycle(32'h0005_A5A5, 20'h2, ONES);
    chk("b2b_cnt", cnt1, 8'd6);
    chk("b2b_sbeg", s_beg1, 52'h5A5A5_A5A5A5A5);
    cycle(32'h1234_5678, 20'h1, ONES);
    chk("repeat_cnt", cnt1, 8'd7);
    chk("repeat_sbeg", s_beg1, 52'h5A5A5_12345678);
    cycle(32'hFFFF_FFFF, 20'h400, ONES);
    chk("sat_nonlocal_cnt_w2", cnt0, 2'd3);

    // Random stream with an asynchronous reset pulse in the middle
    for (int i = 0; i < 60; i++) begin
      if (i == 30) begin
        RST = 1'b1;
        #1;
        reset_model();
        check_outputs();
        chk("arst_fd_o_p2", fd_o2, 32'h0);
        chk("arst_fs_o_p1", fs_o1, 20'h0);
        RST = 1'b0;
        #1;
      end
      rd = $urandom;
      rn = {$urandom, $urandom} & ONES;
      case ($urandom_range(0, 3))
        0:       rs = 20'h0;
        1:       rs = 20'd1 << $urandom_range(0, 1);
        2:       rs = 20'd1 << $urandom_range(0, 19);
        default: rs = 20'($urandom);
      endcase
      cycle(rd, rs, rn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
